// File: rtl/gate_exhaustive_tester.sv
// Exhaustive sequencer for a small combinational gate under test: steps every input
// vector, waits a settle time, compares the gate output to a truth table, reports results.
module gate_exhaustive_tester #(
  parameter int unsigned        N_IN        = 3,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE = 8'h57,
  parameter int unsigned        SETTLE      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop_on_fail,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0]      SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

  state_t          r_state;
  logic [N_IN-1:0] r_vec;
  logic [7:0]      r_settle;
  logic            r_sof;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_ff_vec;
  logic            r_ff_valid;
  logic            w_mismatch;

  // Case-inequality so an X/Z gate output is flagged rather than silently matching.
  always_comb begin
    w_mismatch = (dut_out !== TRUTH_TABLE[r_vec]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_settle   <= '0;
      r_sof      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_cnt  <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec      <= '0;
            r_settle   <= SETTLE_LD;
            r_err_cnt  <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
            r_done     <= 1'b0;
            r_sof      <= stop_on_fail;
            r_busy     <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_settle == '0) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + ERR_ONE;
            if (!r_ff_valid) begin
              r_ff_vec   <= r_vec;
              r_ff_valid <= 1'b1;
            end
          end
          if ((r_vec == VEC_LAST) || (r_sof && w_mismatch)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_vec    <= r_vec + VEC_ONE;
            r_settle <= SETTLE_LD;
            r_state  <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_in           = r_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_done && (r_err_cnt == '0);
  assign err_cnt          = r_err_cnt;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Directed bench for gate_exhaustive_tester driving a behavioural OAI21 with selectable faults.
module tb_gate_exhaustive_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0 correct OAI21, 1 stuck-at-0, 2 miswired ~((c|b)&a)
  int n;

  gate_exhaustive_tester #(
    .N_IN(3),
    .TRUTH_TABLE(8'h57),
    .SETTLE(1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop_on_fail(stop_on_fail),
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = ~((dut_in[0] | dut_in[1]) & dut_in[2]);
      default: dut_out = ~((dut_in[2] | dut_in[1]) & dut_in[0]);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for the next edge, then count cycles until done (bounded).
  task automatic run(input logic sof, input logic sof_after, output int cyc);
    start = 1'b1;
    stop_on_fail = sof;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = sof_after;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(posedge clk); #1;
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_ffvalid", 32'(first_fail_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct gate, per-cycle dut_in stepping, done on the 16th edge
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ok_busy0", 32'(busy), 32'd1);
    chk("ok_vec0", 32'(dut_in), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        chk($sformatf("ok_vec_c%0d", k), 32'(dut_in), 32'(k / 2));
        chk($sformatf("ok_notdone_c%0d", k), 32'(done), 32'd0);
      end
    end
    chk("ok_done", 32'(done), 32'd1);
    chk("ok_busy", 32'(busy), 32'd0);
    chk("ok_pass", 32'(pass), 32'd1);
    chk("ok_err", 32'(err_cnt), 32'd0);
    chk("ok_ffvalid", 32'(first_fail_valid), 32'd0);
    chk("ok_last_vec", 32'(dut_in), 32'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("ok_hold_done", 32'(done), 32'd1);
    chk("ok_hold_vec", 32'(dut_in), 32'd7);

    // Stuck-at-0, stop_on_fail=0 at start; raising it mid-run must not matter
    mode = 1;
    run(1'b0, 1'b1, n);
    chk("s0_cycles", 32'(n), 32'd16);
    chk("s0_err", 32'(err_cnt), 32'd5);
    chk("s0_ffvec", 32'(first_fail_vec), 32'd0);
    chk("s0_ffvalid", 32'(first_fail_valid), 32'd1);
    chk("s0_pass", 32'(pass), 32'd0);

    // Restart from DONE clears results on the accepting edge; stop_on_fail=1
    start = 1'b1;
    stop_on_fail = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = 1'b0;
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_err", 32'(err_cnt), 32'd0);
    chk("rs_ffvalid", 32'(first_fail_valid), 32'd0);
    chk("rs_vec", 32'(dut_in), 32'd0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sof_cycles", 32'(n), 32'd2);
    chk("sof_err", 32'(err_cnt), 32'd1);
    chk("sof_ffvec", 32'(first_fail_vec), 32'd0);
    chk("sof_vec", 32'(dut_in), 32'd0);
    chk("sof_pass", 32'(pass), 32'd0);

    // Miswired gate: vectors 3 and 6 differ
    mode = 2;
    run(1'b0, 1'b0, n);
    chk("mw_cycles", 32'(n), 32'd16);
    chk("mw_err", 32'(err_cnt), 32'd2);
    chk("mw_ffvec", 32'(first_fail_vec), 32'd3);
    chk("mw_pass", 32'(pass), 32'd0);

    // Start pulsed while in WAIT at vec=2 is ignored
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 4) begin
        chk("ign_vec2", 32'(dut_in), 32'd2);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("ign_cycles", 32'(n), 32'd16);
    chk("ign_pass", 32'(pass), 32'd1);

    // Asynchronous reset mid-run at vec=4
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (dut_in != 3'd4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mr_reach4", 32'(n), 32'd8);
    chk("mr_err_pre", 32'(err_cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_vec", 32'(dut_in), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_pass", 32'(pass), 32'd0);
    chk("mr_err", 32'(err_cnt), 32'd0);
    chk("mr_ffvec", 32'(first_fail_vec), 32'd0);
    chk("mr_ffvalid", 32'(first_fail_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk); #1;
    chk("mr_idle_busy", 32'(busy), 32'd0);
    run(1'b0, 1'b0, n);
    chk("mr_run_cycles", 32'(n), 32'd16);
    chk("mr_run_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
